// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a sync FIFO and sends each as an 8N1 UART frame.
// Optional even-parity slot between data and stop when UART_PARITY_EN is defined.
`default_nettype none

module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
`ifdef UART_PARITY_EN
    , PARITY = 3'd6
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    baud_q, baud_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             fifo_rd_q, fifo_rd_d;
  logic             busy_q, busy_d;
  logic             tx_done_q, tx_done_d;
  logic             baud_wrap;
`ifdef UART_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      fifo_rd_q <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      fifo_rd_q <= fifo_rd_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
`ifdef UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_rd_d = 1'b0;
`ifdef UART_PARITY_EN
    parity_d  = parity_q;
`endif
    baud_wrap = (baud_q == BAUD_LAST);

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (enable && !fifo_empty) begin
          state_d   = FETCH;
          fifo_rd_d = 1'b1;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        // FIFO output is registered, so the popped byte is only valid here
        shift_d = fifo_data;
`ifdef UART_PARITY_EN
        parity_d = ^fifo_data;
`endif
        tx_d    = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        if (baud_wrap) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        if (baud_wrap) begin
          if (bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        if (baud_wrap) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        tx_d   = 1'b1;
        if (baud_wrap) begin
          if (enable && !fifo_empty) begin
            state_d   = FETCH;
            fifo_rd_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Flags are derived from the next state so they line up with the registered state
    busy_d    = (state_d != IDLE);
    tx_done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
  end

  assign fifo_rd = fifo_rd_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with a behavioural 16-deep FIFO source.
`default_nettype none

module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int P = NSLOT * CPB + 2;  // FETCH + LOAD + frame

  logic       clk = 1'b0;
  logic       rst_n, enable;
  logic       fifo_empty, fifo_full;
  logic [7:0] fifo_dout;
  logic       fifo_rd, tx, busy, tx_done;

  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] mem [16];
  logic [3:0] wp = 4'd0, rp = 4'd0;
  logic [4:0] cnt = 5'd0;
  logic       underflow = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_dout), .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  // Behavioural sync FIFO with registered read data
  assign fifo_empty = (cnt == 5'd0);
  assign fifo_full  = (cnt == 5'd16);
  initial fifo_dout = 8'h00;
  always @(posedge clk) begin
    logic do_rd, do_wr;
    do_rd = (fifo_rd === 1'b1) && (cnt != 5'd0);
    do_wr = wr_en && (cnt != 5'd16);
    if (fifo_rd === 1'b1 && cnt == 5'd0) underflow <= 1'b1;
    if (do_rd) begin
      fifo_dout <= mem[rp];
      rp <= rp + 4'd1;
    end
    if (do_wr) begin
      mem[wp] <= wr_data;
      wp <= wp + 4'd1;
    end
    if (do_wr && !do_rd) cnt <= cnt + 5'd1;
    else if (do_rd && !do_wr) cnt <= cnt - 5'd1;
  end

  function automatic logic exp_tx(input logic [7:0] d, input int s);
    if (s == 0) return 1'b0;
    if (s <= 8) return d[s-1];
`ifdef UART_PARITY_EN
    if (s == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({tx, fifo_rd, busy, tx_done} !== 4'b1000) begin
      $display("FAIL reset_state: got tx/rd/busy/done=%b want 1000", {tx, fifo_rd, busy, tx_done});
      miscompares++;
    end
    rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if ({tx, fifo_rd, busy, tx_done} !== 4'b1000) begin
        $display("FAIL idle_empty cyc%0d: got tx/rd/busy/done=%b want 1000", i, {tx, fifo_rd, busy, tx_done});
        miscompares++;
      end
    end
  endtask

  task automatic test_single_byte;
    logic [7:0] d = 8'h55;
    int t;
    enable = 1'b0;
    push(d);
    enable = 1'b1;
    for (t = 0; t < 10 && fifo_rd !== 1'b1; t++) @(negedge clk);
    vectors++;
    if (fifo_rd !== 1'b1) begin
      $display("FAIL single_rd_timeout: got fifo_rd=%b want 1", fifo_rd);
      miscompares++;
      return;
    end
    for (int i = 1; i <= P; i++) begin
      @(negedge clk);
      if (i >= 2 && i < P && ((i - 2) % CPB) == 1) begin
        vectors++;
        if (tx !== exp_tx(d, (i - 2) / CPB)) begin
          $display("FAIL single_tx slot%0d: got %b want %b", (i - 2) / CPB, tx, exp_tx(d, (i - 2) / CPB));
          miscompares++;
        end
      end
      vectors++;
      if (tx_done !== (i == P - 1) || fifo_rd !== 1'b0) begin
        $display("FAIL single_pulses cyc%0d: got done=%b rd=%b want done=%b rd=0", i, tx_done, fifo_rd, i == P - 1);
        miscompares++;
      end
      vectors++;
      if (busy !== (i < P)) begin
        $display("FAIL single_busy cyc%0d: got %b want %b", i, busy, i < P);
        miscompares++;
      end
    end
  endtask

  task automatic test_burst;
    logic [7:0] d [3] = '{8'h00, 8'hFF, 8'hA5};
    int t, f, j;
    enable = 1'b0;
    for (int k = 0; k < 3; k++) push(d[k]);
    enable = 1'b1;
    for (t = 0; t < 10 && fifo_rd !== 1'b1; t++) @(negedge clk);
    vectors++;
    if (fifo_rd !== 1'b1) begin
      $display("FAIL burst_rd_timeout: got fifo_rd=%b want 1", fifo_rd);
      miscompares++;
      return;
    end
    for (int i = 0; i < 3 * P; i++) begin
      f = i / P;
      j = i % P;
      vectors++;
      if (tx !== ((j < 2) ? 1'b1 : exp_tx(d[f], (j - 2) / CPB)) || fifo_rd !== (j == 0) ||
          tx_done !== (j == P - 1) || busy !== 1'b1) begin
        $display("FAIL burst cyc%0d: got tx=%b rd=%b done=%b busy=%b want tx=%b rd=%b done=%b busy=1",
                 i, tx, fifo_rd, tx_done, busy, (j < 2) ? 1'b1 : exp_tx(d[f], (j - 2) / CPB),
                 j == 0, j == P - 1);
        miscompares++;
      end
      @(negedge clk);
    end
    vectors++;
    if (busy !== 1'b0 || fifo_empty !== 1'b1 || underflow !== 1'b0) begin
      $display("FAIL burst_end: got busy=%b empty=%b underflow=%b want 0 1 0", busy, fifo_empty, underflow);
      miscompares++;
    end
  endtask

  task automatic test_enable_gate;
    logic [7:0] d [16];
    int t, f, j, rds;
    enable = 1'b0;
    for (int k = 0; k < 16; k++) begin
      d[k] = 8'(k * 37 + 5);
      push(d[k]);
    end
    rds = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd === 1'b1) rds++;
    end
    vectors++;
    if (rds != 0 || fifo_full !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL gate_disabled: got rds=%0d full=%b busy=%b want 0 1 0", rds, fifo_full, busy);
      miscompares++;
    end
    enable = 1'b1;
    for (t = 0; t < 10 && fifo_rd !== 1'b1; t++) @(negedge clk);
    vectors++;
    if (fifo_rd !== 1'b1) begin
      $display("FAIL gate_rd_timeout: got fifo_rd=%b want 1", fifo_rd);
      miscompares++;
      return;
    end
    for (int i = 0; i < 16 * P; i++) begin
      f = i / P;
      j = i % P;
      vectors++;
      if (tx !== ((j < 2) ? 1'b1 : exp_tx(d[f], (j - 2) / CPB)) || fifo_rd !== (j == 0)) begin
        $display("FAIL gate_frame cyc%0d: got tx=%b rd=%b want tx=%b rd=%b",
                 i, tx, fifo_rd, (j < 2) ? 1'b1 : exp_tx(d[f], (j - 2) / CPB), j == 0);
        miscompares++;
      end
      if (i == 0 || i == 1) begin
        vectors++;
        if (fifo_full !== (i == 0)) begin
          $display("FAIL gate_full cyc%0d: got %b want %b", i, fifo_full, i == 0);
          miscompares++;
        end
      end
      if (i == 15 * P || i == 15 * P + 1) begin
        vectors++;
        if (fifo_empty !== (i == 15 * P + 1)) begin
          $display("FAIL gate_empty cyc%0d: got %b want %b", i, fifo_empty, i == 15 * P + 1);
          miscompares++;
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (busy !== 1'b0 || underflow !== 1'b0) begin
      $display("FAIL gate_end: got busy=%b underflow=%b want 0 0", busy, underflow);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d2 = 8'h5A;
    int t, rds;
    enable = 1'b0;
    push(8'hC3);
    push(d2);
    enable = 1'b1;
    for (t = 0; t < 10 && fifo_rd !== 1'b1; t++) @(negedge clk);
    vectors++;
    if (fifo_rd !== 1'b1) begin
      $display("FAIL abort_rd_timeout: got fifo_rd=%b want 1", fifo_rd);
      miscompares++;
      return;
    end
    repeat (19) @(negedge clk);
    vectors++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL abort_bit3: got tx=%b busy=%b want 0 1", tx, busy);
      miscompares++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({tx, fifo_rd, busy, tx_done} !== 4'b1000) begin
      $display("FAIL abort_reset: got tx/rd/busy/done=%b want 1000", {tx, fifo_rd, busy, tx_done});
      miscompares++;
    end
    rst_n = 1'b1;
    for (t = 0; t < 10 && fifo_rd !== 1'b1; t++) @(negedge clk);
    vectors++;
    if (fifo_rd !== 1'b1) begin
      $display("FAIL abort_next_rd_timeout: got fifo_rd=%b want 1", fifo_rd);
      miscompares++;
      return;
    end
    for (int i = 0; i < P; i++) begin
      vectors++;
      if (tx !== ((i < 2) ? 1'b1 : exp_tx(d2, (i - 2) / CPB)) || tx_done !== (i == P - 1)) begin
        $display("FAIL abort_next cyc%0d: got tx=%b done=%b want tx=%b done=%b",
                 i, tx, tx_done, (i < 2) ? 1'b1 : exp_tx(d2, (i - 2) / CPB), i == P - 1);
        miscompares++;
      end
      @(negedge clk);
    end
    rds = 0;
    for (int i = 0; i < 20; i++) begin
      if (fifo_rd === 1'b1 || busy !== 1'b0) rds++;
      @(negedge clk);
    end
    vectors++;
    if (rds != 0 || fifo_empty !== 1'b1) begin
      $display("FAIL abort_no_resend: got activity=%0d empty=%b want 0 1", rds, fifo_empty);
      miscompares++;
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    logic [7:0] d [2] = '{8'h07, 8'h03};
    logic       pexp [2] = '{1'b1, 1'b0};
    int t;
    enable = 1'b0;
    push(d[0]);
    push(d[1]);
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (t = 0; t < 10 && fifo_rd !== 1'b1; t++) @(negedge clk);
      vectors++;
      if (fifo_rd !== 1'b1) begin
        $display("FAIL parity_rd_timeout: got fifo_rd=%b want 1", fifo_rd);
        miscompares++;
        return;
      end
      for (int i = 0; i < P; i++) begin
        if (i == 2 + 9 * CPB + 1) begin
          vectors++;
          if (tx !== pexp[k]) begin
            $display("FAIL parity_slot byte%0d: got %b want %b", k, tx, pexp[k]);
            miscompares++;
          end
        end
        if (i == P - 1) begin
          vectors++;
          if (tx_done !== 1'b1 || i != 45) begin
            $display("FAIL parity_len byte%0d: got done=%b at cyc%0d want 1 at cyc45", k, tx_done, i);
            miscompares++;
          end
        end
        @(negedge clk);
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    test_reset;
    test_single_byte;
    test_burst;
    test_enable_gate;
    test_reset_mid_frame;
`ifdef UART_PARITY_EN
    test_parity;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
